// File: rtl/carregador_matriz.sv
// Loader that packs signed matrix elements row-major for the determinant ALU,
// holds the matrix for the ALU latency and presents det/overflow on a valid/accept handshake.
module carregador_matriz #(
  parameter int LATENCIA_ULA = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   tamanho_in,
  input  logic [7:0]   elem_in,
  input  logic         elem_valid,
  output logic         elem_ready,
  output logic [199:0] matriz,
  output logic [1:0]   tamanho_matriz,
  input  logic [7:0]   det_ula,
  input  logic         ovf_ula,
  output logic [7:0]   det_out,
  output logic         overflow_out,
  output logic         resultado_valido,
  input  logic         resultado_aceito,
  output logic         ocupado
);

  localparam int DATA_W   = 8;
  localparam int MAT_W    = 200;
  localparam int ESPERA_W = (LATENCIA_ULA < 2) ? 1 : $clog2(LATENCIA_ULA + 1);

  localparam logic [1:0] OCIOSO    = 2'd0;
  localparam logic [1:0] CARREGA   = 2'd1;
  localparam logic [1:0] AGUARDA   = 2'd2;
  localparam logic [1:0] RESULTADO = 2'd3;

  logic [1:0]                estado;
  logic [4:0]                cont_elem;
  logic [ESPERA_W-1:0]       cont_espera;
  logic [MAT_W-1:0]          matriz_p0;
  logic [1:0]                tamanho_p0;
  logic signed [DATA_W-1:0]  det_ula_s;
  logic signed [DATA_W-1:0]  det_p0;
  logic                      ovf_p0;
  logic                      vld_p0;
  logic                      transf;
  logic [4:0]                ultimo_idx;
  logic [7:0]                desloc;

  // Index of the last row-major element for each size code (N-1, N = (t+2)^2).
  function automatic logic [4:0] ultimo_elem(input logic [1:0] t);
    case (t)
      2'd0:    return 5'd3;
      2'd1:    return 5'd8;
      2'd2:    return 5'd15;
      default: return 5'd24;
    endcase
  endfunction

  assign elem_ready       = (estado == OCIOSO) || (estado == CARREGA);
  assign ocupado          = (estado != OCIOSO);
  assign transf           = elem_valid && elem_ready;
  assign ultimo_idx       = ultimo_elem(tamanho_p0);
  assign desloc           = {cont_elem, 3'b000};
  assign det_ula_s        = det_ula;

  assign matriz           = matriz_p0;
  assign tamanho_matriz   = tamanho_p0;
  assign det_out          = det_p0;
  assign overflow_out     = ovf_p0;
  assign resultado_valido = vld_p0;

  // Stage p0: element packing, ALU wait and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado      <= OCIOSO;
      cont_elem   <= '0;
      cont_espera <= '0;
      matriz_p0   <= '0;
      tamanho_p0  <= '0;
      det_p0      <= '0;
      ovf_p0      <= 1'b0;
      vld_p0      <= 1'b0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (transf) begin
            tamanho_p0 <= tamanho_in;
            matriz_p0  <= {{(MAT_W-DATA_W){1'b0}}, elem_in};
            cont_elem  <= 5'd1;
            estado     <= CARREGA;
          end
        end
        CARREGA: begin
          if (transf) begin
            matriz_p0[desloc +: DATA_W] <= elem_in;
            cont_elem                   <= cont_elem + 5'd1;
            if (cont_elem == ultimo_idx) begin
              cont_espera <= '0;
              estado      <= AGUARDA;
            end
          end
        end
        AGUARDA: begin
          // The ALU output is settled LATENCIA_ULA cycles after the last matrix write.
          if (cont_espera == ESPERA_W'(LATENCIA_ULA)) begin
            det_p0 <= det_ula_s;
            ovf_p0 <= ovf_ula;
            vld_p0 <= 1'b1;
            estado <= RESULTADO;
          end else begin
            cont_espera <= cont_espera + ESPERA_W'(1);
          end
        end
        RESULTADO: begin
          if (resultado_aceito) begin
            vld_p0 <= 1'b0;
            estado <= OCIOSO;
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_carregador_matriz.sv
// Bench for carregador_matriz: directed and randomized loads, a stub ALU with fixed latency,
// and a transaction-level model compared against the DUT on every falling edge.
module tb_carregador_matriz;

  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   tamanho_in;
  logic [7:0]   elem_in;
  logic         elem_valid;
  logic         elem_ready;
  logic [199:0] matriz;
  logic [1:0]   tamanho_matriz;
  logic [7:0]   det_ula;
  logic         ovf_ula;
  logic [7:0]   det_out;
  logic         overflow_out;
  logic         resultado_valido;
  logic         resultado_aceito;
  logic         ocupado;

  int checks = 0;
  int errors = 0;

  carregador_matriz #(.LATENCIA_ULA(LAT)) dut (
    .clk(clk), .rst(rst), .tamanho_in(tamanho_in), .elem_in(elem_in),
    .elem_valid(elem_valid), .elem_ready(elem_ready), .matriz(matriz),
    .tamanho_matriz(tamanho_matriz), .det_ula(det_ula), .ovf_ula(ovf_ula),
    .det_out(det_out), .overflow_out(overflow_out), .resultado_valido(resultado_valido),
    .resultado_aceito(resultado_aceito), .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [199:0] got, input logic [199:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Determinant of the matrix held in a packed bus; only 2x2 and 3x3 are computed.
  function automatic int det_of(input logic [199:0] m, input logic [1:0] t);
    int e [9];
    for (int k = 0; k < 9; k++) e[k] = int'($signed(m[8*k +: 8]));
    case (t)
      2'd0:    return e[0]*e[3] - e[1]*e[2];
      2'd1:    return e[0]*(e[4]*e[8] - e[5]*e[7]) - e[1]*(e[3]*e[8] - e[5]*e[6])
                    + e[2]*(e[3]*e[7] - e[4]*e[6]);
      default: return 0;
    endcase
  endfunction

  function automatic logic [8:0] pack_det(input int d);
    logic ov;
    ov = (d > 127) || (d < -128);
    return {ov, d[7:0]};
  endfunction

  // Stub ALU: LAT register stages from matriz to det_ula/ovf_ula.
  logic [8:0] alu_a, alu_b;
  always @(posedge clk) begin
    alu_a <= pack_det(det_of(matriz, tamanho_matriz));
    alu_b <= alu_a;
  end
  assign det_ula = alu_b[7:0];
  assign ovf_ula = alu_b[8];

  // Transaction-level model
  logic [199:0] m_mat;
  logic [1:0]   m_tam;
  int           m_cnt, m_n, m_wait, m_d;
  bit           m_done, m_vld;
  logic [7:0]   m_det;
  logic         m_ovf;

  always @(negedge clk) begin
    if (rst) begin
      m_mat = '0; m_tam = '0; m_cnt = 0; m_n = 0; m_wait = 0;
      m_done = 0; m_vld = 0; m_det = '0; m_ovf = 1'b0;
    end
    check("ready", 200'(elem_ready), 200'(!m_done));
    check("ocupado", 200'(ocupado), 200'(m_cnt != 0));
    check("matriz", matriz, m_mat);
    check("tamanho", 200'(tamanho_matriz), 200'(m_tam));
    check("valido", 200'(resultado_valido), 200'(m_vld));
    check("det", 200'(det_out), 200'(m_det));
    check("ovf", 200'(overflow_out), 200'(m_ovf));
    if (!rst) begin
      if (m_done) begin
        if (m_vld) begin
          if (resultado_aceito) begin
            m_done = 0; m_vld = 0; m_cnt = 0;
          end
        end else begin
          m_wait++;
          if (m_wait == LAT + 1) begin
            m_d   = det_of(m_mat, m_tam);
            m_det = m_d[7:0];
            m_ovf = (m_d > 127) || (m_d < -128);
            m_vld = 1;
          end
        end
      end else if (elem_valid) begin
        if (m_cnt == 0) begin
          m_tam = tamanho_in;
          m_n   = (int'(tamanho_in) + 2) ** 2;
          m_mat = '0;
        end
        m_mat[8*m_cnt +: 8] = elem_in;
        m_cnt++;
        if (m_cnt == m_n) begin
          m_done = 1; m_wait = 0;
        end
      end
    end
  end

  task automatic beat(input logic [1:0] t, input logic [7:0] v);
    bit ok;
    int guard;
    guard = 0;
    elem_valid = 1'b1; tamanho_in = t; elem_in = v;
    forever begin
      @(negedge clk); ok = elem_ready;
      @(posedge clk); #1;
      if (ok) break;
      guard++;
      if (guard > 100) begin
        check("beat_timeout", 200'(0), 200'(1));
        break;
      end
    end
    elem_valid = 1'b0;
  endtask

  task automatic load(input logic [1:0] t, input int q[$]);
    foreach (q[i]) beat(t, q[i][7:0]);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!resultado_valido && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!resultado_valido) check("valid_timeout", 200'(0), 200'(1));
  endtask

  task automatic accept(input int hold);
    repeat (hold) begin @(posedge clk); #1; end
    resultado_aceito = 1'b1;
    @(posedge clk); #1;
    resultado_aceito = 1'b0;
  endtask

  initial begin
    int q[$];
    int n;
    logic [199:0] snap;
    logic [1:0] t;
    rst = 1'b0; elem_valid = 1'b0; resultado_aceito = 1'b0;
    tamanho_in = '0; elem_in = '0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ready", 200'(elem_ready), 200'(1));
    check("rst_ocupado", 200'(ocupado), 200'(0));
    check("rst_matriz", matriz, 200'(0));

    // 2x2 basic
    q = '{3, 2, 1, 4};
    load(2'd0, q);
    wait_valid(n);
    check("lat_2x2", 200'(n), 200'(LAT + 1));
    check("mat_2x2_lo", 200'(matriz[31:0]), 200'(32'h04010203));
    check("mat_2x2_hi", 200'(matriz[199:32]), 200'(0));
    check("det_2x2", 200'(det_out), 200'(8'd10));
    check("ovf_2x2", 200'(overflow_out), 200'(0));
    accept(0);

    // 3x3 with a 3-cycle gap after beat 4
    q = '{2, 0, 1, 1};
    load(2'd1, q);
    repeat (3) begin
      @(posedge clk); #1;
      check("gap_ready", 200'(elem_ready), 200'(1));
    end
    q = '{3, 2, 1, 1, 2};
    load(2'd1, q);
    check("ready_after_9", 200'(elem_ready), 200'(0));
    check("mat_3x3", 200'(matriz[71:0]), 200'(72'h020101020301010002));
    wait_valid(n);
    check("det_3x3", 200'(det_out), 200'(8'd6));
    check("ovf_3x3", 200'(overflow_out), 200'(0));
    accept(1);

    // 2x2 overflow: 100*100 = 10000 wraps to 0x10
    q = '{100, 0, 0, 100};
    load(2'd0, q);
    wait_valid(n);
    check("det_ovf", 200'(det_out), 200'(8'h10));
    check("ovf_ovf", 200'(overflow_out), 200'(1));
    accept(0);

    // Result hold with an element waiting
    q = '{1, 2, 3, 4};
    load(2'd0, q);
    wait_valid(n);
    snap = matriz;
    elem_valid = 1'b1; tamanho_in = 2'd0; elem_in = 8'hFF;
    repeat (5) begin
      @(posedge clk); #1;
      check("hold_valid", 200'(resultado_valido), 200'(1));
      check("hold_det", 200'(det_out), 200'(8'hFE));
      check("hold_mat", matriz, snap);
      check("hold_ready", 200'(elem_ready), 200'(0));
    end
    resultado_aceito = 1'b1;
    @(posedge clk); #1;
    resultado_aceito = 1'b0;
    check("acc_valid", 200'(resultado_valido), 200'(0));
    check("acc_ready", 200'(elem_ready), 200'(1));
    q = '{-1, 0, 0, -1};
    load(2'd0, q);
    wait_valid(n);
    check("det_neg", 200'(det_out), 200'(8'd1));
    accept(0);

    // Asynchronous reset mid-load
    q = '{1, 2, 3, 4, 5};
    load(2'd1, q);
    #2 rst = 1'b1;
    #1;
    check("arst_matriz", matriz, 200'(0));
    check("arst_tam", 200'(tamanho_matriz), 200'(0));
    check("arst_det", 200'(det_out), 200'(0));
    check("arst_ovf", 200'(overflow_out), 200'(0));
    check("arst_valid", 200'(resultado_valido), 200'(0));
    check("arst_ready", 200'(elem_ready), 200'(1));
    check("arst_ocupado", 200'(ocupado), 200'(0));
    @(posedge clk); #1 rst = 1'b0;
    q = '{3, 2, 1, 4};
    load(2'd0, q);
    wait_valid(n);
    check("det_after_rst", 200'(det_out), 200'(8'd10));
    accept(0);

    // 5x5 of ones
    for (int k = 0; k < 25; k++) beat(2'd3, 8'd1);
    check("ready_after_25", 200'(elem_ready), 200'(0));
    check("mat_5x5", matriz, {25{8'h01}});
    wait_valid(n);
    check("det_5x5", 200'(det_out), 200'(0));
    check("ovf_5x5", 200'(overflow_out), 200'(0));
    accept(2);

    // Randomized loads with gaps, stray size codes and accept delays
    for (int r = 0; r < 40; r++) begin
      t = 2'($urandom_range(0, 3));
      for (int k = 0; k < (int'(t) + 2) ** 2; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          elem_in = 8'($urandom);
          repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        end
        beat((k == 0) ? t : 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      end
      wait_valid(n);
      check("rand_lat", 200'(n), 200'(LAT + 1));
      accept($urandom_range(0, 3));
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/carregador_matriz.md
Name: carregador_matriz

Overview:
- Upstream feeder for the determinant ALU stage.
- Accepts signed 8-bit matrix elements one per beat over a valid/ready handshake. Packs them row-major into the 200-bit matriz bus and drives tamanho_matriz.
- Holds both stable while the ALU computes, captures det/overflow after a fixed latency, and presents the result on a valid/accept handshake.

Parameters:
- LATENCIA_ULA, 1, clock cycles from a registered matriz change to valid det/overflow at the ALU output (must be >= 1).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- tamanho_in  in  2  matrix size for the next load: 00=2x2, 01=3x3, 10=4x4, 11=5x5
- elem_in  in  8  signed element, two's complement
- elem_valid  in  1  elem_in/tamanho_in valid
- elem_ready  out  1  loader can accept an element
- matriz  out  200  packed matrix to the ALU
- tamanho_matriz  out  2  size code to the ALU
- det_ula  in  8  signed determinant from the ALU
- ovf_ula  in  1  overflow flag from the ALU
- det_out  out  8  captured signed determinant
- overflow_out  out  1  captured overflow flag
- resultado_valido  out  1  det_out/overflow_out valid
- resultado_aceito  in  1  consumer accepts the result
- ocupado  out  1  high in any state except OCIOSO

Behaviour:
- Reset (async, immediate): state OCIOSO; matriz=0, tamanho_matriz=00, det_out=0, overflow_out=0, resultado_valido=0, element counter=0, wait counter=0.
- Output values in OCIOSO after reset: elem_ready=1, ocupado=0.
- Element count N = (tamanho+2)^2, giving 4/9/16/25 elements.
- Packing: element k (row-major, k=0 is row0/col0) is placed at matriz[8k+7:8k]. Bits above 8N-1 are 0.
- A beat transfers on a rising edge when elem_valid=1 and elem_ready=1.
- elem_ready is 1 in OCIOSO and CARREGA, 0 in AGUARDA and RESULTADO. It is a combinational decode of state.
- OCIOSO:
  - On a transfer: latch tamanho_in into tamanho_matriz.
  - Clear all of matriz, then write element 0 at [7:0]. The previous matrix is held until this edge.
  - Counter=1, go to CARREGA.
  - If N would be 1 (impossible for any size code), no special handling.
- CARREGA:
  - Each transfer writes element k=counter and increments counter.
  - tamanho_in is ignored in CARREGA.
  - The transfer of element N-1 (edge E) goes to AGUARDA with wait counter=0.
  - Gaps in elem_valid are allowed, with no timeout.
- AGUARDA:
  - matriz and tamanho_matriz are held constant.
  - The wait counter increments each cycle.
  - At edge E+LATENCIA_ULA+1: capture det_ula into det_out and ovf_ula into overflow_out, set resultado_valido=1, go to RESULTADO.
  - This gives a total latency from the last element beat to resultado_valido of LATENCIA_ULA+1 cycles.
- RESULTADO:
  - det_out, overflow_out and matriz are held.
  - On an edge with resultado_aceito=1: resultado_valido=0, go to OCIOSO.
  - An element presented in the same cycle is not accepted (elem_ready=0). It is accepted at the earliest on the next edge.
- resultado_aceito outside RESULTADO is ignored.
- Size codes 10/11 load normally. The ALU returns det=0, ovf=0 for them, and that result is passed through unchanged.
- Reset mid-load, mid-wait or mid-result: the partial matrix and any pending result are discarded, and all registers return to reset values.
- No arithmetic is done in this block. Values are passed bit-exact and signed.

Test Plan:
- 2x2 load, size 00, elements 3,2,1,4, no gaps. Required:
  - matriz[31:0]=0x04010203, upper bits 0.
  - resultado_valido rises exactly LATENCIA_ULA+1 cycles after the 4th beat.
  - det_out=10, overflow_out=0.
- 3x3 load, size 01, elements 2,0,1,1,3,2,1,1,2, with elem_valid dropped for 3 cycles after beat 4. Required:
  - elem_ready stays 1 during the gap, and exactly 9 beats are accepted.
  - det_out=6, overflow_out=0.
- 2x2 overflow, elements 100,0,0,100. Required: overflow_out=1, and det_out equals the ALU's wrapped output captured unchanged.
- Result hold: keep resultado_aceito=0 for 5 cycles after valid. Required:
  - resultado_valido, det_out and matriz remain stable, and elem_ready=0.
  - Assert aceito: valid drops next edge, elem_ready=1, and the next load of 2x2 elements -1,0,0,-1 gives det_out=1.
- Reset mid-load: assert rst asynchronously after beat 5 of a 3x3 load. Required:
  - All outputs go immediately to reset values.
  - A fresh 2x2 load 3,2,1,4 completes with det_out=10.
- Size 11, 25 beats of value 1. Required:
  - matriz = 25 bytes of 0x01.
  - elem_ready drops after beat 25, and det_out=0, overflow_out=0.
